factor_game_ctrl: RTL and testbench

FACTOR_GAME_CTRL -- requirements
Module: factor_game_ctrl

---
 rtl/factor_game_ctrl.sv | 110 +++++++++++
 tb/tb_factor_game_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/factor_game_ctrl.sv
// factor_game_ctrl: factor-guessing game controller (question, answer select, judge, score).
// Define FACTOR_GAME_TIMEOUT_EN to add an INPUT timeout that forces a wrong answer.
module factor_game_ctrl #(
  parameter int Q_TICKS = 50000000,
  parameter int R_TICKS = 50000000,
  parameter int ROUNDS  = 5,
  parameter int T_TICKS = 250000000
) (
  input  logic       CLK,
  input  logic       nRST,
  input  logic       BTN_START,
  input  logic       BTN_NEXT,
  input  logic       BTN_ENTER,
  output logic [3:0] STATE,
  output logic [3:0] QUE,
  output logic [3:0] SEG_Q,
  output logic [3:0] SCORE,
  output logic       LED_OK,
  output logic       LED_NG,
  output logic       DONE
);
  typedef enum logic [3:0] {
    IDLE = 4'd1, READY = 4'd2, QUESTION = 4'd3, INPUT = 4'd4, JUDGE = 4'd5, RESULT = 4'd6
  } state_t;
  localparam logic [31:0] QL = 32'(Q_TICKS - 1);
  localparam logic [31:0] RL = 32'(R_TICKS - 1);
  localparam logic [3:0]  RN = 4'(ROUNDS);
  localparam logic [3:0]  MAP [16] = '{4'd0, 4'd2, 4'd3, 4'd5, 4'd7, 4'd1, 4'd3, 4'd7,
                                       4'd9, 4'd3, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
  state_t      state, state_n;
  logic [2:0]  s1, s2, s3, vld, pulse;
  logic        start, next, enter, correct, expired;
  logic [2:0]  cnt8;
  logic [31:0] timer;
  logic [3:0]  rnd, div;
  // vld keeps the edge detector blind until s3 holds a real sample, so a button held through reset never fires
  assign pulse = s2 & ~s3 & {3{vld[2]}};
  assign {enter, next, start} = pulse;
  assign div = MAP[SEG_Q];
  assign correct = !expired && div > 4'd1 && (QUE % div) == 4'd0;
  assign STATE = state;
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) begin
      s1  <= '0;
      s2  <= '0;
      s3  <= '0;
      vld <= '0;
    end else begin
      s1  <= {BTN_ENTER, BTN_NEXT, BTN_START};
      s2  <= s1;
      s3  <= s2;
      vld <= {vld[1:0], 1'b1};
    end
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:     state_n = start ? READY : IDLE;
      READY:    state_n = start ? QUESTION : READY;
      QUESTION: state_n = timer == QL ? INPUT : QUESTION;
`ifdef FACTOR_GAME_TIMEOUT_EN
      INPUT:    state_n = (enter && SEG_Q != 4'd0) || timer == 32'(T_TICKS - 1) ? JUDGE : INPUT;
`else
      INPUT:    state_n = enter && SEG_Q != 4'd0 ? JUDGE : INPUT;
`endif
      JUDGE:    state_n = RESULT;
      RESULT:   state_n = timer == RL ? (rnd + 4'd1 == RN ? IDLE : READY) : RESULT;
      default:  state_n = IDLE;
    endcase
  end
`ifdef FACTOR_GAME_TIMEOUT_EN
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) expired <= 1'b0;
    else expired <= state == INPUT && state_n == JUDGE && !(enter && SEG_Q != 4'd0);
`else
  assign expired = 1'b0;
`endif
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) begin
      cnt8   <= '0;
      timer  <= '0;
      QUE    <= '0;
      SEG_Q  <= '0;
      SCORE  <= '0;
      rnd    <= '0;
      DONE   <= 1'b0;
      LED_OK <= 1'b0;
      LED_NG <= 1'b0;
    end else begin
      cnt8   <= cnt8 + 3'd1;
      timer  <= state_n != state ? '0 : timer + 32'd1;
      LED_OK <= state_n == RESULT && (state == JUDGE ? correct : LED_OK);
      LED_NG <= state_n == RESULT && (state == JUDGE ? !correct : LED_NG);
      if (state == IDLE && start) begin
        SCORE <= '0;
        rnd   <= '0;
        DONE  <= 1'b0;
      end
      if (state == READY && start) QUE <= 4'd2 + {1'b0, cnt8};
      if (state == QUESTION && state_n == INPUT) SEG_Q <= '0;
      if (state == INPUT && next && !enter) SEG_Q <= SEG_Q == 4'd9 ? 4'd1 : SEG_Q + 4'd1;
      if (state == JUDGE && correct && SCORE != 4'hf) SCORE <= SCORE + 4'd1;
      if (state == RESULT && timer == RL) begin
        rnd  <= rnd + 4'd1;
        DONE <= rnd + 4'd1 == RN;
      end
    end
endmodule

// File: tb/tb_factor_game_ctrl.sv
// tb_factor_game_ctrl: table-driven rounds plus hand sequences for reset, ignored ENTER and timeout.
module tb_factor_game_ctrl;
  logic CLK = 1'b0, nRST = 1'b0, BTN_START = 1'b0, BTN_NEXT = 1'b0, BTN_ENTER = 1'b0;
  logic [3:0] STATE, QUE, SEG_Q, SCORE;
  logic LED_OK, LED_NG, DONE;
  int checks = 0, errors = 0, cyc;

  factor_game_ctrl #(.Q_TICKS(4), .R_TICKS(3), .ROUNDS(2), .T_TICKS(8)) dut (
    .CLK(CLK), .nRST(nRST), .BTN_START(BTN_START), .BTN_NEXT(BTN_NEXT), .BTN_ENTER(BTN_ENTER),
    .STATE(STATE), .QUE(QUE), .SEG_Q(SEG_Q), .SCORE(SCORE), .LED_OK(LED_OK), .LED_NG(LED_NG),
    .DONE(DONE));

  always #5 CLK = ~CLK;
  // mirrors the free-running mod-8 question counter: edges since reset release
  always @(posedge CLK or negedge nRST)
    if (!nRST) cyc <= 0;
    else cyc <= cyc + 1;

  typedef struct {
    int         que;
    int         nexts;
    logic [3:0] seg;
    logic       ok;
    logic [3:0] score;
    logic       done;
  } vec_t;
  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_state(input logic [3:0] s, input int limit, input string name);
    for (int n = 0; n < limit && STATE !== s; n++) @(negedge CLK);
    chk(name, STATE, s);
  endtask

  task automatic set_btn(input int b, input logic v);
    if (b == 0) BTN_START = v;
    else if (b == 1) BTN_NEXT = v;
    else BTN_ENTER = v;
  endtask

  task automatic press(input int b);
    set_btn(b, 1'b1);
    repeat (2) @(negedge CLK);
    set_btn(b, 1'b0);
    repeat (2) @(negedge CLK);
  endtask

  // START pressed after edge k loads QUE = 2 + (k+2) mod 8, so press when cyc%8 == m
  task automatic start_question(input int que);
    int m;
    m = (que + 4) % 8;
    repeat (4) @(negedge CLK);
    while (cyc % 8 != m) @(negedge CLK);
    BTN_START = 1'b1;
  endtask

  task automatic do_round(input vec_t v, input int idx);
    if (STATE === 4'd1) begin
      press(0);
      wait_state(4'd2, 8, $sformatf("r%0d_to_ready", idx));
      chk($sformatf("r%0d_done_clr", idx), DONE, 0);
      chk($sformatf("r%0d_score_clr", idx), SCORE, 0);
    end
    start_question(v.que);
    repeat (3) @(negedge CLK);
    BTN_START = 1'b0;
    chk($sformatf("r%0d_question", idx), STATE, 3);
    chk($sformatf("r%0d_que", idx), QUE, v.que);
    repeat (3) @(negedge CLK);
    chk($sformatf("r%0d_q_hold", idx), STATE, 3);
    @(negedge CLK);
    chk($sformatf("r%0d_input", idx), STATE, 4);
    chk($sformatf("r%0d_seg_init", idx), SEG_Q, 0);
    repeat (v.nexts) press(1);
    chk($sformatf("r%0d_seg", idx), SEG_Q, v.seg);
    BTN_ENTER = 1'b1;
    wait_state(4'd5, 8, $sformatf("r%0d_judge", idx));
    BTN_ENTER = 1'b0;
    chk($sformatf("r%0d_judge_leds", idx), {LED_OK, LED_NG}, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk($sformatf("r%0d_result", idx), STATE, 6);
      chk($sformatf("r%0d_led_ok", idx), LED_OK, v.ok);
      chk($sformatf("r%0d_led_ng", idx), LED_NG, !v.ok);
    end
    @(negedge CLK);
    chk($sformatf("r%0d_after", idx), STATE, v.done ? 1 : 2);
    chk($sformatf("r%0d_leds_off", idx), {LED_OK, LED_NG}, 0);
    chk($sformatf("r%0d_score", idx), SCORE, v.score);
    chk($sformatf("r%0d_done", idx), DONE, v.done);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{6, 1,  4'd1, 1'b1, 4'd1, 1'b0};
    vecs[1] = '{7, 10, 4'd1, 1'b0, 4'd1, 1'b1};
    vecs[2] = '{9, 8,  4'd8, 1'b1, 4'd1, 1'b0};
    vecs[3] = '{5, 3,  4'd3, 1'b1, 4'd2, 1'b1};
    vecs[4] = '{2, 5,  4'd5, 1'b0, 4'd0, 1'b0};
    vecs[5] = '{8, 9,  4'd9, 1'b0, 4'd0, 1'b1};
    repeat (3) @(negedge CLK);
    chk("rst_state", STATE, 1);
    chk("rst_que", QUE, 0);
    chk("rst_seg", SEG_Q, 0);
    chk("rst_score", SCORE, 0);
    chk("rst_leds", {LED_OK, LED_NG}, 0);
    chk("rst_done", DONE, 0);
    nRST = 1'b1;
    repeat (2) @(negedge CLK);
    for (int i = 0; i < 6; i++) do_round(vecs[i], i);
    // ENTER on dash is ignored; NEXT+ENTER together acts as ENTER only
    press(0);
    wait_state(4'd2, 8, "b_ready0");
    start_question(6);
    wait_state(4'd4, 12, "b_input");
    BTN_START = 1'b0;
    chk("b_que", QUE, 6);
    press(2);
    repeat (4) @(negedge CLK);
    chk("b_enter_dash", STATE, 4);
    chk("b_seg_dash", SEG_Q, 0);
    press(1);
    press(1);
    chk("b_seg2", SEG_Q, 2);
    BTN_NEXT = 1'b1;
    BTN_ENTER = 1'b1;
    wait_state(4'd5, 8, "b_judge");
    BTN_NEXT = 1'b0;
    BTN_ENTER = 1'b0;
    chk("b_seg_kept", SEG_Q, 2);
    @(negedge CLK);
    chk("b_led_ok", LED_OK, 1);
    wait_state(4'd2, 8, "b_ready1");
    chk("b_score", SCORE, 1);
    chk("b_done", DONE, 0);
    // reset in RESULT, START held through release
    press(0);
    wait_state(4'd4, 12, "c_input");
    press(1);
    BTN_ENTER = 1'b1;
    wait_state(4'd6, 10, "c_result");
    BTN_ENTER = 1'b0;
    nRST = 1'b0;
    #1;
    chk("c_state", STATE, 1);
    chk("c_que", QUE, 0);
    chk("c_seg", SEG_Q, 0);
    chk("c_score", SCORE, 0);
    chk("c_leds", {LED_OK, LED_NG}, 0);
    chk("c_done", DONE, 0);
    BTN_START = 1'b1;
    repeat (2) @(negedge CLK);
    nRST = 1'b1;
    repeat (8) @(negedge CLK);
    chk("c_held_start", STATE, 1);
    BTN_START = 1'b0;
    repeat (3) @(negedge CLK);
    press(0);
    wait_state(4'd2, 8, "c_ready");
    // INPUT timeout; the NEXT press must not restart the timer
    press(0);
    wait_state(4'd4, 12, "d_input");
    BTN_NEXT = 1'b1;
    repeat (2) @(negedge CLK);
    BTN_NEXT = 1'b0;
    repeat (5) @(negedge CLK);
    chk("d_input_n7", STATE, 4);
    @(negedge CLK);
`ifdef FACTOR_GAME_TIMEOUT_EN
    chk("d_timeout_judge", STATE, 5);
    @(negedge CLK);
    chk("d_led_ng", LED_NG, 1);
    chk("d_led_ok", LED_OK, 0);
    chk("d_seg", SEG_Q, 1);
`else
    chk("d_no_timeout", STATE, 4);
    repeat (20) @(negedge CLK);
    chk("d_still_input", STATE, 4);
    chk("d_seg", SEG_Q, 1);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
